// File: rtl/mdu_pkg.sv
// Shared constants for the M-extension execute unit: funct3 op codes, the
// R-type M-bit decode, and divider state encodings.
package mdu_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_ARITH = 7'b0110011;
  localparam logic [6:0] FUNCT7_M     = 7'b0000001;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } div_state_e;

  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_ARITH) && (funct7 == FUNCT7_M);
  endfunction

endpackage

// File: rtl/mdu_pipe_div_iter.sv
// Iterative radix-2 restoring divider: sign handling, RISC-V special cases,
// and a DONE state that holds the result until the result port is granted.
module div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [ROB_POS_W-1:0] rob_pos,
  input  logic                 grant,
  output logic                 idle,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_val,
  output logic [ROB_POS_W-1:0] out_rob_pos
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  div_state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [XLEN-1:0]      quo_q, rem_q, dsr_q, res_q;
  logic                 q_neg_q, r_neg_q, is_rem_q, spec_q;
  logic [ROB_POS_W-1:0] rob_q;

  logic            is_signed, is_rem_op, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, fix_q, fix_r;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    is_signed = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    is_rem_op = (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    a_neg     = is_signed && val1[XLEN-1];
    b_neg     = is_signed && val2[XLEN-1];
    a_abs     = a_neg ? -val1 : val1;
    b_abs     = b_neg ? -val2 : val2;
    div_zero  = (val2 == '0);
    ovf       = is_signed && (val1 == {1'b1, {(XLEN-1){1'b0}}}) && (val2 == '1);
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dsr_q};
    fix_q     = q_neg_q ? -quo_q : quo_q;
    fix_r     = r_neg_q ? -rem_q : rem_q;
  end

  // Special cases detour through FIX so they share the result path.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        DivIdle: if (start) state_d = (div_zero || ovf) ? DivFix : DivCalc;
        DivCalc: if (cnt_q == CntW'(1)) state_d = DivFix;
        DivFix:  state_d = DivDone;
        DivDone: if (grant) state_d = DivIdle;
        default: state_d = DivIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) state_q <= DivIdle;
    else                 state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      case (state_q)
        DivIdle: begin
          if (start) begin
            rob_q    <= rob_pos;
            is_rem_q <= is_rem_op;
            cnt_q    <= CntW'(XLEN);
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            dsr_q    <= b_abs;
            if (div_zero) begin
              spec_q <= 1'b1;
              quo_q  <= '1;
              rem_q  <= val1;
            end else if (ovf) begin
              spec_q <= 1'b1;
              quo_q  <= val1;
              rem_q  <= '0;
            end else begin
              spec_q <= 1'b0;
              quo_q  <= a_abs;
              rem_q  <= '0;
            end
          end
        end
        DivCalc: begin
          cnt_q <= cnt_q - CntW'(1);
          quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
        DivFix: begin
          if (spec_q) res_q <= is_rem_q ? rem_q : quo_q;
          else        res_q <= is_rem_q ? fix_r : fix_q;
        end
        default: ;
      endcase
    end
  end

  assign idle        = (state_q == DivIdle);
  assign out_valid   = (state_q == DivDone);
  assign out_val     = res_q;
  assign out_rob_pos = rob_q;

endmodule

// File: rtl/mdu_pipe.sv
// RV M-extension execute unit: fixed-latency multiply pipeline plus iterative
// divider sharing one CDB result port; the multiply pipe always wins the port.
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned ROB_POS_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [ROB_POS_W-1:0] rob_pos,
  output logic                 result,
  output logic [ROB_POS_W-1:0] result_rob_pos,
  output logic [XLEN-1:0]      result_val,
  output logic                 div_busy
);

  localparam int unsigned Last = MUL_STAGES - 1;

  logic                 div_idle, div_valid, div_start, div_grant, mul_acc;
  logic [XLEN-1:0]      div_val, mul_val;
  logic [ROB_POS_W-1:0] div_rob;

  logic                   a_sx, b_sx;
  logic [2*XLEN-1:0]      a_w, b_w, prod;
  logic [MUL_STAGES-1:0]  mv_q;
  logic [2*XLEN-1:0]      mp_q [MUL_STAGES];
  logic [2:0]             mf_q [MUL_STAGES];
  logic [ROB_POS_W-1:0]   mr_q [MUL_STAGES];

  assign issue_ready = !funct3[2] || div_idle;
  assign div_busy    = !div_idle;
  assign mul_acc     = issue_valid && !funct3[2] && rdy;
  assign div_start   = issue_valid && funct3[2] && div_idle && rdy && !rollback;
  assign div_grant   = rdy && !mv_q[Last];

  // Sign-extending to 2*XLEN makes the modular product equal the
  // (XLEN+1)-bit signed product in the bits we keep.
  always_comb begin
    a_sx = ((funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU)) && val1[XLEN-1];
    b_sx = (funct3 == FUNCT3_MULH) && val2[XLEN-1];
    a_w  = {{XLEN{a_sx}}, val1};
    b_w  = {{XLEN{b_sx}}, val2};
    prod = a_w * b_w;
  end

  always_comb begin
    mul_val = mp_q[Last][XLEN-1:0];
    case (mf_q[Last])
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: mul_val = mp_q[Last][2*XLEN-1:XLEN];
      default:                                  mul_val = mp_q[Last][XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      mv_q <= '0;
    end else if (rdy) begin
      mv_q[0] <= mul_acc;
      for (int unsigned i = 1; i < MUL_STAGES; i++) mv_q[i] <= mv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      mp_q[0] <= prod;
      mf_q[0] <= funct3;
      mr_q[0] <= rob_pos;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        mp_q[i] <= mp_q[i-1];
        mf_q[i] <= mf_q[i-1];
        mr_q[i] <= mr_q[i-1];
      end
    end
  end

  div_iter #(
    .XLEN      (XLEN),
    .ROB_POS_W (ROB_POS_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .start       (div_start),
    .funct3      (funct3),
    .val1        (val1),
    .val2        (val2),
    .rob_pos     (rob_pos),
    .grant       (div_grant),
    .idle        (div_idle),
    .out_valid   (div_valid),
    .out_val     (div_val),
    .out_rob_pos (div_rob)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result         <= 1'b0;
      result_rob_pos <= '0;
      result_val     <= '0;
    end else if (rollback) begin
      result <= 1'b0;
    end else if (rdy) begin
      result <= mv_q[Last] || div_valid;
      if (mv_q[Last]) begin
        result_rob_pos <= mr_q[Last];
        result_val     <= mul_val;
      end else if (div_valid) begin
        result_rob_pos <= div_rob;
        result_val     <= div_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// Bench for mdu_pipe: directed scenarios then random traffic, all checked
// against an arithmetic reference model with a per-cycle result schedule.
module tb_mdu_pipe;
  import mdu_pkg::*;

  localparam int unsigned MS = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_valid;
  logic [2:0]  funct3;
  logic [31:0] val1, val2;
  logic [3:0]  rob_pos;
  logic        issue_ready, result, div_busy;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned due;
    logic [3:0]  rob;
    logic [31:0] val;
  } pend_t;

  pend_t       mq[$];
  bit          dpend;
  int unsigned dready, ecyc;
  logic [3:0]  drob, exp_rob;
  logic [31:0] dval, exp_val;
  logic        exp_res;

  mdu_pipe #(.XLEN(32), .MUL_STAGES(MS), .ROB_POS_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .funct3         (funct3),
    .val1           (val1),
    .val2           (val2),
    .rob_pos        (rob_pos),
    .result         (result),
    .result_rob_pos (result_rob_pos),
    .result_val     (result_val),
    .div_busy       (div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      FUNCT3_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      FUNCT3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      FUNCT3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      FUNCT3_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      FUNCT3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      FUNCT3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      FUNCT3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:       return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 0) return 2;
    if ((f3 == FUNCT3_DIV || f3 == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 2;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check issue_ready, advance the model, check outputs.
  task automatic step(input logic r, input logic rb, input logic iv, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] rp);
    bit    pre;
    pend_t e;
    rdy = r; rollback = rb; issue_valid = iv; funct3 = f3; val1 = a; val2 = b; rob_pos = rp;
    #1;
    chk("issue_ready", 32'(issue_ready), 32'(!f3[2] || !dpend));
    @(posedge clk);
    if (rb) begin
      mq.delete();
      dpend   = 0;
      exp_res = 1'b0;
    end else if (r) begin
      ecyc++;
      pre     = dpend;
      exp_res = 1'b0;
      if (mq.size() > 0 && mq[0].due == ecyc) begin
        exp_res = 1'b1; exp_rob = mq[0].rob; exp_val = mq[0].val;
        void'(mq.pop_front());
      end else if (dpend && dready <= ecyc) begin
        exp_res = 1'b1; exp_rob = drob; exp_val = dval;
        dpend   = 0;
      end
      if (iv && !f3[2]) begin
        e.due = ecyc + MS; e.rob = rp; e.val = ref_op(f3, a, b);
        mq.push_back(e);
      end else if (iv && !pre) begin
        dpend  = 1;
        dready = ecyc + ref_lat(f3, a, b);
        drob   = rp;
        dval   = ref_op(f3, a, b);
      end
    end
    #1;
    chk("result", 32'(result), 32'(exp_res));
    chk("result_rob_pos", 32'(result_rob_pos), 32'(exp_rob));
    chk("result_val", result_val, exp_val);
    chk("div_busy", 32'(div_busy), 32'(dpend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 4'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
    funct3 = 3'b000; val1 = '0; val2 = '0; rob_pos = '0;
    mq.delete(); dpend = 0; ecyc = 0; exp_res = 1'b0; exp_rob = '0; exp_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_rob_pos", 32'(result_rob_pos), 32'h0);
    chk("rst_val", result_val, 32'h0);
    chk("rst_div_busy", 32'(div_busy), 32'h0);

    // Back-to-back multiplies
    step(1, 0, 1, FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 4'd1);
    step(1, 0, 1, FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    idle(1);
    chk("mul_lit", result_val, 32'hFFFF_FFEB);
    idle(1);
    chk("mulhu_lit", result_val, 32'hFFFF_FFFE);

    // Divides with full-length iteration
    step(1, 0, 1, FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 4'd3);
    idle(34);
    chk("div_lit", result_val, 32'hFFFF_FFFD);
    step(1, 0, 1, FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 4'd4);
    idle(34);
    chk("rem_lit", result_val, 32'hFFFF_FFFF);
    step(1, 0, 1, FUNCT3_DIVU, 32'd100, 32'd7, 4'd5);
    idle(34);
    chk("divu_lit", result_val, 32'd14);
    step(1, 0, 1, FUNCT3_REMU, 32'd100, 32'd7, 4'd6);
    idle(34);
    chk("remu_lit", result_val, 32'd2);

    // Special cases, two-cycle latency
    step(1, 0, 1, FUNCT3_DIV, 32'h1234_5678, 32'h0, 4'd7);
    idle(2);
    chk("div0_lit", result_val, 32'hFFFF_FFFF);
    step(1, 0, 1, FUNCT3_REM, 32'h1234_5678, 32'h0, 4'd8);
    idle(2);
    chk("rem0_lit", result_val, 32'h1234_5678);
    step(1, 0, 1, FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9);
    idle(2);
    chk("divovf_lit", result_val, 32'h8000_0000);
    step(1, 0, 1, FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
    idle(2);
    chk("removf_lit", result_val, 32'h0);

    // Multiply and divide finish together; mul first, second divide refused meanwhile
    step(1, 0, 1, FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 4'd11);
    idle(31);
    step(1, 0, 1, FUNCT3_MUL, 32'd3, 32'd5, 4'd12);
    step(1, 0, 1, FUNCT3_DIVU, 32'd10, 32'd3, 4'd13);
    step(1, 0, 1, FUNCT3_DIVU, 32'd10, 32'd3, 4'd13);
    chk("arb_mul_first", result_val, 32'd15);
    idle(1);
    chk("arb_div_next", result_val, 32'hFFFF_FFFD);

    // Rollback mid-divide with a multiply in flight
    step(1, 0, 1, FUNCT3_DIV, 32'd1000, 32'd3, 4'd1);
    idle(4);
    step(1, 0, 1, FUNCT3_MUL, 32'd9, 32'd9, 4'd2);
    step(1, 1, 1, FUNCT3_DIV, 32'd50, 32'd5, 4'd3);
    step(1, 0, 1, FUNCT3_DIVU, 32'd100, 32'd7, 4'd4);
    idle(34);
    chk("post_rollback_div", result_val, 32'd14);

    // Five-cycle stall mid-divide
    step(1, 0, 1, FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5);
    idle(10);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, FUNCT3_MUL, 32'd2, 32'd2, 4'd6);
    idle(23);
    chk("stall_not_yet", 32'(result), 32'h0);
    idle(1);
    chk("stall_div_lit", result_val, 32'hFFFF_FFFD);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom_range(0, 15)));
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
